// File: rtl/sprite_line_fetcher_if.sv
// Shared sprite frameRAM read port.
// The fetcher (master) drives the read address. The RAM (slave) returns
// the texel one clock after the address, because the read is registered.
//   rom_addr : 15-bit read address, driven by the fetcher
//   rom_data : 24-bit RGB texel, returned by the RAM one cycle after rom_addr
interface sprite_line_fetcher_if;
  logic [14:0] rom_addr;
  logic [23:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite fetch scheduler.
//
// During each horizontal blank the fetcher walks the object slots. For every
// slot that intersects the next scanline, it copies that sprite row from the
// shared frameRAM port into the slot's row buffer. During active video it
// produces one priority-resolved, transparency-keyed sprite pixel per DrawX,
// one cycle after DrawX is presented.
//
// Ports:
//   Clk, Reset            pixel clock; synchronous active-high reset
//   DrawX, DrawY          current beam position
//   obj_en, obj_size      per-slot enable; size select (0 = 8x8, 1 = 32x32)
//   obj_x, obj_y          per-slot top-left corner, 10 bits per slot, packed
//   obj_base              per-slot frameRAM image base, 15 bits per slot, packed
//   rom                   shared frameRAM read port (master side)
//   pix_rgb, pix_valid    sprite pixel for the previous cycle's DrawX
//   busy                  a row fetch is in progress
//   overrun               sticky: the fetch did not finish within hblank
module sprite_line_fetcher #(
  parameter int          NUM_SLOTS   = 4,
  parameter logic [23:0] TRANSPARENT = 24'hFF0000,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_TOTAL     = 525
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [NUM_SLOTS-1:0]     obj_en,
  input  logic [NUM_SLOTS-1:0]     obj_size,
  input  logic [10*NUM_SLOTS-1:0]  obj_x,
  input  logic [10*NUM_SLOTS-1:0]  obj_y,
  input  logic [15*NUM_SLOTS-1:0]  obj_base,
  sprite_line_fetcher_if.master    rom,
  output logic [23:0]              pix_rgb,
  output logic                     pix_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [9:0] H_ACTIVE_V = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_V = 10'd480;
  localparam logic [9:0] LAST_LINE  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LAST     = 10'd799;

  // Shadow copies of the object table. These are captured at the trigger,
  // so game-logic updates never tear a displayed line.
  logic [NUM_SLOTS-1:0] sh_en_reg;
  logic [NUM_SLOTS-1:0] sh_size_reg;
  logic [9:0]           sh_x_reg    [NUM_SLOTS];
  logic [9:0]           sh_y_reg    [NUM_SLOTS];
  logic [14:0]          sh_base_reg [NUM_SLOTS];

  logic [1:0]           state_reg;
  logic [SW-1:0]        slot_reg;
  logic [4:0]           col_reg;
  logic [4:0]           row_reg;
  logic [9:0]           next_y_reg;
  logic [NUM_SLOTS-1:0] row_hit_reg;
  logic                 overrun_reg;

  // Write-back pipeline. It tracks the slot and column of the address
  // issued on the previous cycle, so the registered ROM data lands in the
  // correct buffer entry.
  logic                 wr_valid_reg;
  logic [SW-1:0]        wr_slot_reg;
  logic [4:0]           wr_col_reg;

  logic        trigger;
  logic        slot_last;
  logic        scan_hit;
  logic [9:0]  scan_row;
  logic [4:0]  col_last;
  logic [9:0]  fetch_offset;
  logic [14:0] fetch_addr;

  assign trigger   = (DrawX == H_ACTIVE_V);
  assign slot_last = (slot_reg == SW'(NUM_SLOTS - 1));

  // Unsigned subtraction: rows above the sprite wrap to large values, so a
  // single compare covers both sides of the sprite.
  assign scan_row = next_y_reg - sh_y_reg[slot_reg];
  assign scan_hit = sh_en_reg[slot_reg] &&
                    (sh_size_reg[slot_reg] ? (scan_row < 10'd32) : (scan_row < 10'd8));
  assign col_last = sh_size_reg[slot_reg] ? 5'd31 : 5'd7;

  // row*size + col reduces to a bit concatenation, because sizes are powers of two.
  assign fetch_offset = sh_size_reg[slot_reg] ? {row_reg, col_reg}
                                              : {4'd0, row_reg[2:0], col_reg[2:0]};
  assign fetch_addr   = sh_base_reg[slot_reg] + {5'd0, fetch_offset};

  assign rom.rom_addr = (state_reg == ST_FETCH) ? fetch_addr : 15'd0;
  assign busy         = (state_reg != ST_IDLE);
  assign overrun      = overrun_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      slot_reg     <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      next_y_reg   <= '0;
      row_hit_reg  <= '0;
      overrun_reg  <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_slot_reg  <= '0;
      wr_col_reg   <= '0;
      sh_en_reg    <= '0;
      sh_size_reg  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_x_reg[i]    <= '0;
        sh_y_reg[i]    <= '0;
        sh_base_reg[i] <= '0;
      end
    end else begin
      wr_valid_reg <= (state_reg == ST_FETCH);
      wr_slot_reg  <= slot_reg;
      wr_col_reg   <= col_reg;

      if ((DrawX == H_LAST) && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end

      if (trigger) begin
        // A trigger that finds the previous fetch still running restarts it.
        if (state_reg != ST_IDLE) begin
          overrun_reg <= 1'b1;
        end
        next_y_reg  <= (DrawY == LAST_LINE) ? 10'd0 : DrawY + 10'd1;
        sh_en_reg   <= obj_en;
        sh_size_reg <= obj_size;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          sh_x_reg[i]    <= obj_x[i*10 +: 10];
          sh_y_reg[i]    <= obj_y[i*10 +: 10];
          sh_base_reg[i] <= obj_base[i*15 +: 15];
        end
        row_hit_reg <= '0;
        slot_reg    <= '0;
        state_reg   <= ST_SCAN;
      end else begin
        case (state_reg)
          ST_SCAN: begin
            if (scan_hit) begin
              row_reg   <= scan_row[4:0];
              col_reg   <= 5'd0;
              state_reg <= ST_FETCH;
            end else if (slot_last) begin
              state_reg <= ST_DRAIN;
            end else begin
              slot_reg <= slot_reg + SW'(1);
            end
          end
          ST_FETCH: begin
            col_reg <= col_reg + 5'd1;
            if (col_reg == col_last) begin
              row_hit_reg[slot_reg] <= 1'b1;
              if (slot_last) begin
                state_reg <= ST_DRAIN;
              end else begin
                slot_reg  <= slot_reg + SW'(1);
                state_reg <= ST_SCAN;
              end
            end
          end
          ST_DRAIN: state_reg <= ST_IDLE;
          default:  state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // Display path. Each slot has its own row buffer with a registered read.
  // The read register and the hit flag together form the single output stage.
  logic                   visible;
  logic [NUM_SLOTS-1:0]   hit_all;
  logic [24*NUM_SLOTS-1:0] tex_all;

  assign visible = (DrawX < H_ACTIVE_V) && (DrawY < V_ACTIVE_V);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [23:0] line_buf [32];
      logic [23:0] tex_reg;
      logic        hit_reg;
      logic [9:0]  rd_col;
      logic        in_span;

      assign rd_col  = DrawX - sh_x_reg[gi];
      assign in_span = sh_size_reg[gi] ? (rd_col < 10'd32) : (rd_col < 10'd8);

      always_ff @(posedge Clk) begin
        if (wr_valid_reg && (wr_slot_reg == SW'(gi))) begin
          line_buf[wr_col_reg] <= rom.rom_data;
        end
        tex_reg <= line_buf[rd_col[4:0]];
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          hit_reg <= 1'b0;
        end else begin
          hit_reg <= row_hit_reg[gi] && in_span && visible;
        end
      end

      assign hit_all[gi]         = hit_reg;
      assign tex_all[gi*24 +: 24] = tex_reg;
    end
  endgenerate

  // Scan from the lowest priority slot to the highest, so that the
  // lowest-index opaque slot overwrites the others.
  always_comb begin
    pix_valid = 1'b0;
    pix_rgb   = 24'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_all[i] && (tex_all[i*24 +: 24] != TRANSPARENT)) begin
        pix_valid = 1'b1;
        pix_rgb   = tex_all[i*24 +: 24];
      end
    end
  end

endmodule
